// File: rtl/alu_cmd_issue_if.sv
// Bundle of the command, ALU-drive and response signals of alu_cmd_issue.
// The slave modport is the issue stage's view. The master modport is the
// view of whatever drives commands, models the ALU and accepts responses.
interface alu_cmd_issue_if #(
  parameter int WIDTH = 8,
  parameter int SHW   = 5,
  parameter int DEPTH = 4
);

  localparam int CW = $clog2(DEPTH) + 1;

  // command side
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_opcode;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [SHW-1:0]   cmd_shift;

  // ALU operand drive and result sampling
  logic [3:0]       alu_opcode;
  logic [WIDTH-1:0] alu_input1;
  logic [WIDTH-1:0] alu_input2;
  logic [SHW-1:0]   alu_shiftValue;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             alu_zero;
  logic             alu_overflow;

  // response side
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [2:0]       rsp_flags;
  logic             rsp_err;

  // status
  logic [CW-1:0]    fifo_count;

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_shift,
    input  alu_result, alu_carry, alu_zero, alu_overflow,
    input  rsp_ready,
    output cmd_ready,
    output alu_opcode, alu_input1, alu_input2, alu_shiftValue,
    output rsp_valid, rsp_result, rsp_flags, rsp_err,
    output fifo_count
  );

  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_shift,
    output alu_result, alu_carry, alu_zero, alu_overflow,
    output rsp_ready,
    input  cmd_ready,
    input  alu_opcode, alu_input1, alu_input2, alu_shiftValue,
    input  rsp_valid, rsp_result, rsp_flags, rsp_err,
    input  fifo_count
  );

endinterface

// File: rtl/alu_cmd_issue.sv
// Command-issue stage in front of a combinational ALU. Commands are queued
// in a small FIFO, then driven onto the ALU from registers. One cycle later
// the result and flags are captured and offered as a registered response,
// so the ALU always sits between two register boundaries.
module alu_cmd_issue #(
  parameter int WIDTH = 8,
  parameter int SHW   = 5,
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            rst_n,
  alu_cmd_issue_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = 4 + 2 * WIDTH + SHW;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [EW-1:0]    mem_q [DEPTH];

  logic [3:0]       alu_opcode_q;
  logic [WIDTH-1:0] alu_input1_q;
  logic [WIDTH-1:0] alu_input2_q;
  logic [SHW-1:0]   alu_shift_q;

  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_result_q;
  logic [2:0]       rsp_flags_q;
  logic             rsp_err_q;

  logic             cmd_ready;
  logic             push;
  logic             load;
  logic             capture;
  logic             fifo_nonempty;
  logic [EW-1:0]    cmd_entry;
  logic [EW-1:0]    head;

  // Ready looks only at the registered count: a pop in the same cycle does
  // not open a slot until the next cycle, keeping ready free of FSM paths.
  assign cmd_ready     = (count_q != CW'(DEPTH));
  assign push          = bus.cmd_valid & cmd_ready;
  assign fifo_nonempty = (count_q != '0);
  assign cmd_entry     = {bus.cmd_opcode, bus.cmd_a, bus.cmd_b, bus.cmd_shift};
  assign head          = mem_q[rd_ptr_q];

  // Issue FSM and FIFO bookkeeping. Loading operands is the FIFO pop; a
  // push is never visible to the pop logic until the following cycle.
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    load        = 1'b0;
    capture     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (fifo_nonempty) begin
          load    = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        capture     = 1'b1;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (fifo_nonempty) begin
            load    = 1'b1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase

    wr_ptr_d = push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = load ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    unique case ({push, load})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state: FSM, FIFO pointers/count and response valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // FIFO storage; contents are only meaningful below the count, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= cmd_entry;
    end
  end

  // ALU operand registers: loaded on pop, otherwise hold the last command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_opcode_q <= '0;
      alu_input1_q <= '0;
      alu_input2_q <= '0;
      alu_shift_q  <= '0;
    end else if (load) begin
      {alu_opcode_q, alu_input1_q, alu_input2_q, alu_shift_q} <= head;
    end
  end

  // Response capture: the ALU has seen stable operands for a full cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else if (capture) begin
      rsp_result_q <= bus.alu_result;
      rsp_flags_q  <= {bus.alu_overflow, bus.alu_zero, bus.alu_carry};
      rsp_err_q    <= (alu_opcode_q > 4'd3);
    end
  end

  assign bus.cmd_ready      = cmd_ready;
  assign bus.alu_opcode     = alu_opcode_q;
  assign bus.alu_input1     = alu_input1_q;
  assign bus.alu_input2     = alu_input2_q;
  assign bus.alu_shiftValue = alu_shift_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_result     = rsp_result_q;
  assign bus.rsp_flags      = rsp_flags_q;
  assign bus.rsp_err        = rsp_err_q;
  assign bus.fifo_count     = count_q;

endmodule

// File: doc/alu_cmd_issue.md
Name: alu_cmd_issue

Overview:
- Command-issue stage directly upstream of the generated combinational ALUs (ROL/ROR/MAX/MIN family).
- Accepts operation commands over a valid/ready interface and buffers them in a small FIFO.
- Drives each command onto the ALU operand ports from registers, then samples the ALU result and flags one cycle later.
- Presents each result downstream over a valid/ready response interface, so the ALU sits between registered boundaries.

Parameters:
WIDTH, 8, operand/result bit width (matches ALU bit width)
SHW, 5, shift-amount width
DEPTH, 4, command FIFO entries (power of two, >=2)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept (= !full, registered)
cmd_opcode  in  4  ALU opcode (0 ROL, 1 ROR, 2 MAX, 3 MIN)
cmd_a  in  WIDTH  operand 1
cmd_b  in  WIDTH  operand 2
cmd_shift  in  SHW  shift amount
alu_opcode  out  4  registered to ALU opcode
alu_input1  out  WIDTH  registered to ALU input1
alu_input2  out  WIDTH  registered to ALU input2
alu_shiftValue  out  SHW  registered to ALU shiftValue
alu_result  in  WIDTH  ALU result (combinational)
alu_carry  in  1  ALU carryFlag
alu_zero  in  1  ALU zeroFlag
alu_overflow  in  1  ALU overFlowFlag
rsp_valid  out  1  response present
rsp_ready  in  1  downstream accepts
rsp_result  out  WIDTH  captured result
rsp_flags  out  3  {overflow, zero, carry} captured
rsp_err  out  1  opcode was > 3
fifo_count  out  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, rst_n=0) sets:
  - all outputs to 0, except cmd_ready=1;
  - FIFO pointers and count to 0;
  - FSM to IDLE.
- Reset mid-operation discards all queued and in-flight commands. No response is produced for them.
- FIFO:
  - push when cmd_valid && cmd_ready; pop when the FSM loads operands;
  - simultaneous push and pop leaves the count unchanged;
  - no push-to-pop bypass: a command pushed at edge N is poppable at edge N+1 at the earliest;
  - pointers wrap modulo DEPTH;
  - cmd_ready is derived from the registered count only, so it is low when count==DEPTH even if a pop occurs that cycle.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: if count>0, pop head into alu_* registers and go to ISSUE; otherwise stay.
  - ISSUE: alu_* have been stable for one full cycle. At the edge, capture alu_result into rsp_result and {alu_overflow, alu_zero, alu_carry} into rsp_flags. Set rsp_err = (alu_opcode > 3) and rsp_valid=1, then go to RESP.
  - RESP: hold rsp_* stable while rsp_valid && !rsp_ready. On rsp_ready, if count>0, pop the next command into alu_* and go to ISSUE (rsp_valid=0 next cycle); else go to IDLE with rsp_valid=0.
- alu_* registers hold their last values when not loading; they are not cleared between commands.
- Latency from accepting a command into an empty, idle block:
  - accepted at edge 0;
  - operands driven after edge 1;
  - rsp_valid=1 after edge 2.
- Sustained throughput with rsp_ready=1 is one response per 2 cycles.
- Capacity with rsp_ready held 0 is DEPTH+1 commands: DEPTH in the FIFO plus one in RESP.
- Ordering: responses come out strictly in command order. No command is dropped or duplicated.
- Illegal opcodes (4..15) are issued normally. The result is whatever the ALU returns (0 for the default arm), with rsp_err=1.
- Arithmetic: none in this block. Widths pass through unchanged.

Test Plan:
- Reset, then cmd {op=0, a=0x81, shift=1} with rsp_ready=1 -> rsp_valid high 2 cycles after accept, rsp_result=0x03, rsp_err=0, then rsp_valid low.
- Back-to-back cmds MAX(0x10,0x20), MIN(0x10,0x20), ROR(0x01, shift 1) with rsp_ready=1 -> responses 0x20, 0x10, 0x80 in order, spaced 2 cycles.
- rsp_ready=0, cmd_valid held with 6 distinct cmds:
  - exactly 5 accepted, then cmd_ready=0 and fifo_count=4;
  - release rsp_ready -> all 5 responses in order;
  - cmd_ready returns 1 the cycle after the first pop.
- MIN(0x00,0x05) -> rsp_result=0x00, rsp_flags[1]=1. Drive alu_carry/alu_overflow=1 from the bench -> rsp_flags=3'b111, captured only at the ISSUE edge.
- cmd op=4'd9 -> rsp_err=1, rsp_result=0x00. The following legal cmd has rsp_err=0.
- Queue 3 cmds, assert rst_n=0 while in RESP -> all outputs 0 immediately (async), cmd_ready=1 after release, no stale responses.
